// File: rtl/tag_match_scanner_if.sv
// Match-address stream from the tag scanner to the row write-back / readout controller.
// The scanner drives valid/addr/last; the consumer drives ready.
interface tag_match_scanner_if #(
    parameter int ADDR_WIDTH = 7
);
    logic                  match_valid;
    logic                  match_ready;
    logic [ADDR_WIDTH-1:0] match_addr;
    logic                  match_last;

    modport master (
        output match_valid,
        output match_addr,
        output match_last,
        input  match_ready
    );

    modport slave (
        input  match_valid,
        input  match_addr,
        input  match_last,
        output match_ready
    );
endinterface

// File: rtl/tag_match_scanner.sv
// Snapshots a tag vector on start and streams the index of every set bit, lowest first,
// one per valid/ready handshake; reports the handshake count and a no-match flag.
module tag_match_scanner #(
    parameter int DATA_DEPTH = 128,
    parameter int ADDR_WIDTH = 7,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [DATA_DEPTH-1:0] tag_in_i,
    tag_match_scanner_if.master   mbus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  match_count_o,
    output logic                  none_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [DATA_DEPTH-1:0] ONE_VEC  = DATA_DEPTH'(1);
    localparam logic [CNT_WIDTH-1:0]  ONE_CNT  = CNT_WIDTH'(1);

    state_e                state_q, state_d;
    logic [DATA_DEPTH-1:0] pending_q, pending_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  none_q, none_d;

    logic                  pendingAny;
    logic                  singleBit;
    logic                  handshake;
    logic [ADDR_WIDTH-1:0] lowestIdx;
    logic [DATA_DEPTH-1:0] pendingLowCleared;

    // x & (x-1) drops the lowest set bit; it doubles as the "exactly one bit left" test.
    assign pendingAny        = |pending_q;
    assign pendingLowCleared = pending_q & (pending_q - ONE_VEC);
    assign singleBit         = pendingAny && (pendingLowCleared == '0);

    always_comb begin
        lowestIdx = '0;
        for (int i = DATA_DEPTH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                lowestIdx = ADDR_WIDTH'(i);
            end
        end
    end

    assign mbus.match_valid = (state_q == SCAN) && pendingAny;
    assign mbus.match_addr  = lowestIdx;
    assign mbus.match_last  = (state_q == SCAN) && singleBit;
    assign handshake        = mbus.match_valid && mbus.match_ready;

    assign busy_o        = (state_q == SCAN) || (state_q == DONE);
    assign done_o        = (state_q == DONE);
    assign match_count_o = count_q;
    assign none_o        = none_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            count_q   <= '0;
            none_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            none_q    <= none_d;
        end
    end

    // none is latched on the way into DONE so it is already visible alongside the done pulse.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        none_d    = none_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    pending_d = tag_in_i;
                    count_d   = '0;
                    none_d    = 1'b0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (pendingAny) begin
                    if (handshake) begin
                        pending_d = pendingLowCleared;
                        count_d   = count_q + ONE_CNT;
                    end
                end else begin
                    none_d  = (count_q == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tag_match_scanner.sv
// Randomised self-checking bench for tag_match_scanner: a queue of expected set-bit
// indices, built directly from each captured vector, is compared against the stream.
module tb_tag_match_scanner;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] tagIn;
    logic         busy;
    logic         done;
    logic [7:0]   matchCount;
    logic         none;

    int passChecks;
    int totalChecks;

    tag_match_scanner_if #(.ADDR_WIDTH(7)) mif ();

    tag_match_scanner #(
        .DATA_DEPTH(128),
        .ADDR_WIDTH(7),
        .CNT_WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .tag_in_i     (tagIn),
        .mbus         (mif.master),
        .busy_o       (busy),
        .done_o       (done),
        .match_count_o(matchCount),
        .none_o       (none)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        totalChecks++;
        if (observed === expected) begin
            passChecks++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] randVec();
        logic [127:0] a;
        logic [127:0] b;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        return a & b;
    endfunction

    task automatic checkIdleOutputs(input string tag, input int expCount, input bit expNone);
        checkOutput({tag, "Valid"}, 128'(mif.match_valid), 128'(0));
        checkOutput({tag, "Busy"},  128'(busy), 128'(0));
        checkOutput({tag, "Done"},  128'(done), 128'(0));
        checkOutput({tag, "Count"}, 128'(matchCount), 128'(expCount));
        checkOutput({tag, "None"},  128'(none), 128'(expNone));
    endtask

    // One complete scan: start, stream every expected index, drain, done pulse, idle hold.
    task automatic applyStimulus(input logic [127:0] vec, input bit randReady, input bit noise);
        int expIdx[$];
        int n;
        int cnt;
        int guard;
        bit ready;
        for (int i = 0; i < 128; i++) begin
            if (vec[i]) expIdx.push_back(i);
        end
        n   = expIdx.size();
        cnt = 0;
        start = 1'b1;
        tagIn = vec;
        mif.match_ready = 1'b0;
        tick();
        start = 1'b0;
        if (noise) tagIn = randVec();
        guard = 0;
        while (expIdx.size() > 0 && guard < 4000) begin
            checkOutput("scanValid", 128'(mif.match_valid), 128'(1));
            checkOutput("scanAddr",  128'(mif.match_addr), 128'(expIdx[0]));
            checkOutput("scanLast",  128'(mif.match_last), 128'(expIdx.size() == 1));
            checkOutput("scanBusy",  128'(busy), 128'(1));
            checkOutput("scanDone",  128'(done), 128'(0));
            checkOutput("scanCount", 128'(matchCount), 128'(cnt));
            ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                tagIn = randVec();
            end
            mif.match_ready = ready;
            if (ready) begin
                void'(expIdx.pop_front());
                cnt++;
            end
            tick();
            guard++;
        end
        if (expIdx.size() > 0) checkOutput("scanBudget", 128'(expIdx.size()), 128'(0));
        mif.match_ready = 1'($urandom_range(0, 1));
        checkOutput("drainValid", 128'(mif.match_valid), 128'(0));
        checkOutput("drainLast",  128'(mif.match_last), 128'(0));
        checkOutput("drainBusy",  128'(busy), 128'(1));
        checkOutput("drainDone",  128'(done), 128'(0));
        tick();
        checkOutput("doneDone",  128'(done), 128'(1));
        checkOutput("doneBusy",  128'(busy), 128'(1));
        checkOutput("doneValid", 128'(mif.match_valid), 128'(0));
        checkOutput("doneCount", 128'(matchCount), 128'(n));
        checkOutput("doneNone",  128'(none), 128'(n == 0));
        start = 1'b0;
        tick();
        checkIdleOutputs("idle", n, n == 0);
        for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
            tagIn = randVec();
            tick();
            checkIdleOutputs("hold", n, n == 0);
        end
    endtask

    initial begin
        logic [127:0] vec;
        passChecks  = 0;
        totalChecks = 0;
        rst   = 1'b0;
        start = 1'b0;
        tagIn = '0;
        mif.match_ready = 1'b0;
        tick();
        tick();
        checkIdleOutputs("reset", 0, 1'b0);
        checkOutput("resetAddr", 128'(mif.match_addr), 128'(0));
        checkOutput("resetLast", 128'(mif.match_last), 128'(0));
        rst = 1'b1;
        tick();

        $display("[TB] three set bits, ready held high");
        applyStimulus(128'h1_0024, 1'b0, 1'b0);
        $display("[TB] empty vector");
        applyStimulus(128'h0, 1'b0, 1'b0);
        $display("[TB] all ones");
        applyStimulus({128{1'b1}}, 1'b0, 1'b0);
        $display("[TB] bits 0 and 127 with random ready");
        vec = '0;
        vec[0]   = 1'b1;
        vec[127] = 1'b1;
        applyStimulus(vec, 1'b1, 1'b0);
        $display("[TB] start pulses mid-scan");
        applyStimulus(128'h8000_0421_0000_1000_0300_0000_0084_2001, 1'b1, 1'b1);
        $display("[TB] random vectors");
        for (int r = 0; r < 8; r++) begin
            applyStimulus(randVec(), 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("[TB] reset mid-scan");
        start = 1'b1;
        tagIn = 128'hF0;
        mif.match_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        mif.match_ready = 1'b0;
        checkOutput("preResetCount", 128'(matchCount), 128'(2));
        checkOutput("preResetAddr",  128'(mif.match_addr), 128'(6));
        #2;
        rst = 1'b0;
        #1;
        checkIdleOutputs("midReset", 0, 1'b0);
        checkOutput("midResetAddr", 128'(mif.match_addr), 128'(0));
        checkOutput("midResetLast", 128'(mif.match_last), 128'(0));
        tick();
        rst = 1'b1;
        tick();
        applyStimulus(128'h0, 1'b0, 1'b0);

        $display("[TB] %0d/%0d checks passed", passChecks, totalChecks);
        $finish;
    end

endmodule
